// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: ALU operations, forwarding selects and
// branch funct3 codes, plus the branch comparator used by the execute stage.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Branch condition on the forwarded register operands; 010/011 never taken.
  function automatic logic branch_cond(input logic [2:0]  f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic taken;
    case (f3)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLT:  taken = ($signed(a) <  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_BLTU: taken = (a <  b);
      BR_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub/logic, signed and unsigned set-less-than,
// and logical left shift by the low five bits of SrcB.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  logic [XLEN-1:0] w_result;

  // Operation select.
  always_comb begin
    case (ALUControl)
      ALU_ADD:  w_result = SrcA + SrcB;
      ALU_SUB:  w_result = SrcA - SrcB;
      ALU_AND:  w_result = SrcA & SrcB;
      ALU_OR:   w_result = SrcA | SrcB;
      ALU_XOR:  w_result = SrcA ^ SrcB;
      ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      ALU_SLL:  w_result = SrcA << SrcB[4:0];
      default:  w_result = {XLEN{1'b0}};
    endcase
  end

  assign ALUResult = w_result;
  assign Zero      = (w_result == {XLEN{1'b0}});

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump redirect and the
// EX/MEM pipeline register.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] InstrE,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            jalrE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [1:0]      ResultSrcE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic [2:0]      funct3M,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM
);

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;
  logic [XLEN-1:0] w_jalr_sum;
  logic [2:0]      w_funct3;
  logic            w_unused;

  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [XLEN-1:0] r_pc_plus4;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;

  assign w_funct3 = InstrE[14:12];
  // Branches compare registers directly, so Zero and the other Instr bits are not consumed here.
  assign w_unused = ^{InstrE[XLEN-1:15], InstrE[11:0], w_zero};

  // Forward mux A: 10 picks our own registered result from the previous instruction.
  always_comb begin
    case (ForwardAE)
      FWD_WB:  w_fwd_a = ResultW;
      FWD_MEM: w_fwd_a = r_alu_result;
      default: w_fwd_a = RD1_E;
    endcase
  end

  // Forward mux B, also the store data source.
  always_comb begin
    case (ForwardBE)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = r_alu_result;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (w_fwd_a),
    .SrcB       (w_src_b),
    .ALUControl (ALUControlE),
    .ALUResult  (w_alu_result),
    .Zero       (w_zero)
  );

  assign w_jalr_sum = w_fwd_a + ImmExtE;
  assign PCTargetE  = jalrE ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
  assign PCSrcE     = JumpE | jalrE | (BranchE & branch_cond(w_funct3, w_fwd_a, w_fwd_b));

  // EX/MEM register: loads every cycle, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_result <= {XLEN{1'b0}};
      r_write_data <= {XLEN{1'b0}};
      r_pc_plus4   <= {XLEN{1'b0}};
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'd0;
    end else begin
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= RdE;
      r_funct3     <= w_funct3;
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
    end
  end

  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign RdM        = r_rd;
  assign funct3M    = r_funct3;
  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: EX/MEM expectations go through a scoreboard
// queue, redirect outputs are checked combinationally.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e, instr_e, result_w;
  logic [4:0]  rd_e;
  logic        regw_e, memw_e, jump_e, jalr_e, branch_e, alusrc_e;
  logic [2:0]  aluctl_e;
  logic [1:0]  ressrc_e, fwd_a, fwd_b;

  logic        pcsrc_e;
  logic [31:0] pctarget_e, alu_m, wd_m, pc4_m;
  logic [4:0]  rd_m;
  logic [2:0]  f3_m;
  logic        regw_m, memw_m;
  logic [1:0]  ressrc_m;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
  } exm_t;

  exm_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  execute_cycle #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RD1_E(rd1_e), .RD2_E(rd2_e), .ImmExtE(imm_e), .PCE(pc_e),
    .PCPlus4E(pc4_e), .InstrE(instr_e), .RdE(rd_e),
    .RegWriteE(regw_e), .MemWriteE(memw_e), .JumpE(jump_e), .jalrE(jalr_e),
    .BranchE(branch_e), .ALUSrcE(alusrc_e), .ALUControlE(aluctl_e),
    .ResultSrcE(ressrc_e), .ForwardAE(fwd_a), .ForwardBE(fwd_b),
    .ResultW(result_w),
    .PCSrcE(pcsrc_e), .PCTargetE(pctarget_e),
    .ALUResultM(alu_m), .WriteDataM(wd_m), .PCPlus4M(pc4_m), .RdM(rd_m),
    .funct3M(f3_m), .RegWriteM(regw_m), .MemWriteM(memw_m), .ResultSrcM(ressrc_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rd1_e = 32'd0; rd2_e = 32'd0; imm_e = 32'd0; pc_e = 32'd0; pc4_e = 32'd0;
    instr_e = 32'd0; result_w = 32'd0; rd_e = 5'd0;
    regw_e = 1'b0; memw_e = 1'b0; jump_e = 1'b0; jalr_e = 1'b0;
    branch_e = 1'b0; alusrc_e = 1'b0; aluctl_e = 3'b000;
    ressrc_e = 2'b00; fwd_a = 2'b00; fwd_b = 2'b00;
  endtask

  task automatic push_expect(input logic [31:0] alu, input logic [31:0] wd);
    exm_t e;
    e.alu = alu; e.wd = wd; e.pc4 = pc4_e; e.rd = rd_e; e.f3 = instr_e[14:12];
    e.rw = regw_e; e.mw = memw_e; e.rs = ressrc_e;
    sb_q.push_back(e);
  endtask

  task automatic push_zero();
    exm_t e;
    e = '0;
    sb_q.push_back(e);
  endtask

  task automatic tick_and_check(input string tag);
    exm_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_alu"}, alu_m, e.alu);
      chk({tag, "_wd"},  wd_m,  e.wd);
      chk({tag, "_pc4"}, pc4_m, e.pc4);
      chk({tag, "_rd"},  32'(rd_m), 32'(e.rd));
      chk({tag, "_f3"},  32'(f3_m), 32'(e.f3));
      chk({tag, "_rw"},  32'(regw_m), 32'(e.rw));
      chk({tag, "_mw"},  32'(memw_m), 32'(e.mw));
      chk({tag, "_rs"},  32'(ressrc_m), 32'(e.rs));
    end
  endtask

  task automatic alu_step(input string tag, input logic [2:0] op, input logic [31:0] exp);
    aluctl_e = op;
    push_expect(exp, 32'h0000_0001);
    tick_and_check(tag);
  endtask

  task automatic branch_step(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic exp_src, input logic [31:0] exp_alu);
    instr_e = {17'd0, f3, 12'd0};
    rd1_e = a; rd2_e = b;
    #1;
    chk({tag, "_pcsrc"}, 32'(pcsrc_e), 32'(exp_src));
    chk({tag, "_target"}, pctarget_e, 32'h0000_0120);
    push_expect(exp_alu, b);
    tick_and_check(tag);
  endtask

  initial begin
    // Reset held for two edges with busy inputs.
    clear_inputs();
    rst = 1'b1;
    rd1_e = 32'h11; rd2_e = 32'h22; imm_e = 32'h33; pc_e = 32'h40; pc4_e = 32'h44;
    instr_e = 32'h0000_2000; rd_e = 5'd9; regw_e = 1'b1; memw_e = 1'b1; ressrc_e = 2'b01;
    push_zero(); tick_and_check("rst1");
    push_zero(); tick_and_check("rst2");
    rst = 1'b0;
    push_expect(32'h33, 32'h22); tick_and_check("rst_release");

    // ALU sweep
    clear_inputs();
    rd1_e = 32'h8000_0000; rd2_e = 32'h0000_0001; rd_e = 5'd3; regw_e = 1'b1;
    alu_step("add",  3'b000, 32'h8000_0001);
    alu_step("sub",  3'b001, 32'h7FFF_FFFF);
    alu_step("and",  3'b010, 32'h0000_0000);
    alu_step("or",   3'b011, 32'h8000_0001);
    alu_step("xor",  3'b100, 32'h8000_0001);
    alu_step("slt",  3'b101, 32'h0000_0001);
    alu_step("sltu", 3'b110, 32'h0000_0000);
    alu_step("sll",  3'b111, 32'h0000_0000);

    // Forwarding, back-to-back dependent ops
    clear_inputs();
    rd1_e = 32'd5; rd2_e = 32'd7; rd_e = 5'd4; regw_e = 1'b1;
    push_expect(32'd12, 32'd7); tick_and_check("fwd_add");
    fwd_a = 2'b10; rd1_e = 32'hDEAD_0000; rd2_e = 32'd3; aluctl_e = 3'b001;
    push_expect(32'd9, 32'd3); tick_and_check("fwd_mem_sub");
    fwd_a = 2'b00; fwd_b = 2'b01; result_w = 32'hA5; rd1_e = 32'd1; aluctl_e = 3'b000;
    push_expect(32'hA6, 32'hA5); tick_and_check("fwd_wb");
    fwd_a = 2'b11; fwd_b = 2'b11; rd1_e = 32'd2; rd2_e = 32'd3;
    push_expect(32'd5, 32'd3); tick_and_check("fwd_11");

    // Branches
    clear_inputs();
    pc_e = 32'h100; imm_e = 32'h20; branch_e = 1'b1; aluctl_e = 3'b001;
    branch_step("beq",  3'b000, 32'd4, 32'd4, 1'b1, 32'd0);
    branch_step("bne",  3'b001, 32'd4, 32'd4, 1'b0, 32'd0);
    branch_step("blt",  3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFE);
    branch_step("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFE);
    branch_step("bge",  3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFE);
    branch_step("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFE);
    branch_step("f3_010", 3'b010, 32'd4, 32'd4, 1'b0, 32'd0);
    // ALUResultM is 0 here, so forwarded A equals RD2=0 and beq is taken
    fwd_a = 2'b10;
    branch_step("beq_fwd", 3'b000, 32'h1234_5678, 32'd0, 1'b1, 32'd0);
    fwd_a = 2'b00; branch_e = 1'b0;
    branch_step("beq_nobr", 3'b000, 32'd4, 32'd4, 1'b0, 32'd0);

    // jalr
    clear_inputs();
    jalr_e = 1'b1; rd1_e = 32'h1003; imm_e = 32'd4; alusrc_e = 1'b1;
    pc_e = 32'h104; pc4_e = 32'h108; regw_e = 1'b1; rd_e = 5'd1; ressrc_e = 2'b10;
    #1;
    chk("jalr_target", pctarget_e, 32'h1006);
    chk("jalr_pcsrc", 32'(pcsrc_e), 32'd1);
    push_expect(32'h1007, 32'd0); tick_and_check("jalr");

    // Jump and branch together
    clear_inputs();
    jump_e = 1'b1; branch_e = 1'b1; instr_e = 32'h0000_1000;
    rd1_e = 32'd4; rd2_e = 32'd4; pc_e = 32'h200; imm_e = 32'h10;
    #1;
    chk("jb_pcsrc", 32'(pcsrc_e), 32'd1);
    chk("jb_target", pctarget_e, 32'h210);
    push_expect(32'd8, 32'd4); tick_and_check("jb");

    // Store
    clear_inputs();
    alusrc_e = 1'b1; imm_e = 32'd8; rd1_e = 32'h200; rd2_e = 32'hDEAD;
    memw_e = 1'b1; instr_e = 32'h0000_2000;
    push_expect(32'h208, 32'hDEAD); tick_and_check("store");

    // Reset mid-instruction; redirect path stays live
    pc_e = 32'h300;
    rst = 1'b1;
    #1;
    chk("rst_target", pctarget_e, 32'h308);
    push_zero(); tick_and_check("rst_mid");
    rst = 1'b0;
    clear_inputs();
    push_expect(32'd0, 32'd0); tick_and_check("bubble");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
